// File: rtl/ack_bus_requester.sv
// ack_bus_requester
//   Buffers completion tags from a local module in a 4-entry in-order FIFO
//   and hands them, one at a time, to a shared ack bus through a
//   request/grant handshake with an external arbiter.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   done_valid    : local completion present this cycle
//   done_tag[2:0] : tag of that completion
//   done_ready    : FIFO has room (combinational, count != 4)
//   req           : request to the ack bus arbiter
//   ack_ready     : grant from the arbiter for this source
//   ack_valid     : this instance drives the ack bus this cycle
//   ack_tag[2:0]  : tag being acknowledged (0 when idle)
//   ack_src[1:0]  : SOURCE_ID while driving (0 when idle)
//   pending[2:0]  : FIFO occupancy, 0..4
//   overflow_err  : sticky, set by a completion offered while full
module ack_bus_requester #(
  parameter logic [1:0] SOURCE_ID = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done_valid,
  input  logic [2:0] done_tag,
  output logic       done_ready,
  output logic       req,
  input  logic       ack_ready,
  output logic       ack_valid,
  output logic [2:0] ack_tag,
  output logic [1:0] ack_src,
  output logic [2:0] pending,
  output logic       overflow_err
);

  typedef enum logic [1:0] {IDLE, REQ, DRIVE} state_t;

  state_t     state;
  logic [2:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count, count_nxt;
  logic       push, pop;

  // done_ready looks only at the pre-edge count, so a pop on the same edge
  // never opens room for a push into a full FIFO.
  assign done_ready = (count != 3'd4);
  assign push       = done_valid & done_ready;
  assign pop        = (state == DRIVE);
  assign count_nxt  = 3'(count + {2'b00, push} - {2'b00, pop});
  assign pending    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= done_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count        <= 3'd0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count_nxt;
      if (done_valid && !done_ready) overflow_err <= 1'b1;
    end
  end

  // Bus-side FSM. Outputs are registered; the head tag is latched on the
  // grant edge, which is safe because nothing pops while in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req       <= 1'b0;
      ack_valid <= 1'b0;
      ack_tag   <= 3'd0;
      ack_src   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 3'd0) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (ack_ready) begin
            state     <= DRIVE;
            req       <= 1'b0;
            ack_valid <= 1'b1;
            ack_tag   <= mem[rd_ptr];
            ack_src   <= SOURCE_ID;
          end
        end
        DRIVE: begin
          // one bus cycle only; re-request if anything is left after the pop
          ack_valid <= 1'b0;
          ack_tag   <= 3'd0;
          ack_src   <= 2'd0;
          if (count_nxt != 3'd0) begin
            state <= REQ;
            req   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req       <= 1'b0;
          ack_valid <= 1'b0;
          ack_tag   <= 3'd0;
          ack_src   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_bus_requester.sv
module tb_ack_bus_requester;
  localparam logic [1:0] SRC = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_valid;
  logic [2:0] done_tag;
  logic       done_ready;
  logic       req;
  logic       grant;
  logic       ack_valid;
  logic [2:0] ack_tag;
  logic [1:0] ack_src;
  logic [2:0] pending;
  logic       overflow_err;

  int errors = 0;
  int checks = 0;

  logic [4:0] sb[$];    // expected {src,tag} for the main instance
  logic [4:0] arb_q[$]; // expected {src,tag} on the shared bus

  always #5 clk = ~clk;

  ack_bus_requester #(.SOURCE_ID(SRC)) dut (
    .clk(clk), .rst_n(rst_n), .done_valid(done_valid), .done_tag(done_tag),
    .done_ready(done_ready), .req(req), .ack_ready(grant), .ack_valid(ack_valid),
    .ack_tag(ack_tag), .ack_src(ack_src), .pending(pending), .overflow_err(overflow_err)
  );

  // four-source system with a fixed-priority arbiter: CTRL, MEM, AES, SHA
  logic [3:0] a_dv, a_rdy, a_req, a_grant, a_av, a_ovf;
  logic [2:0] a_tin [4];
  logic [2:0] a_tag [4];
  logic [2:0] a_pend[4];
  logic [1:0] a_src [4];
  logic       arb_en;

  for (genvar g = 0; g < 4; g++) begin : g_arb
    ack_bus_requester #(.SOURCE_ID(2'(g))) u (
      .clk(clk), .rst_n(rst_n), .done_valid(a_dv[g]), .done_tag(a_tin[g]),
      .done_ready(a_rdy[g]), .req(a_req[g]), .ack_ready(a_grant[g]),
      .ack_valid(a_av[g]), .ack_tag(a_tag[g]), .ack_src(a_src[g]),
      .pending(a_pend[g]), .overflow_err(a_ovf[g])
    );
  end

  always_comb begin
    a_grant = 4'b0000;
    if (arb_en) begin
      if      (a_req[3]) a_grant = 4'b1000;
      else if (a_req[0]) a_grant = 4'b0001;
      else if (a_req[2]) a_grant = 4'b0100;
      else if (a_req[1]) a_grant = 4'b0010;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // main-instance monitor
  always @(negedge clk) begin
    if (rst_n) begin
      chk("no_req_ack_overlap", {31'd0, req & ack_valid}, 32'd0);
      chk("pending_le_4", {31'd0, pending > 3'd4}, 32'd0);
      if (ack_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {27'd0, ack_src, ack_tag}, 32'h3f);
        end else begin
          logic [4:0] e;
          e = sb.pop_front();
          chk("ack_src", {30'd0, ack_src}, {30'd0, e[4:3]});
          chk("ack_tag", {29'd0, ack_tag}, {29'd0, e[2:0]});
        end
      end
    end
  end

  // shared-bus monitor
  always @(negedge clk) begin
    if (rst_n && a_av != 4'b0000) begin
      chk("arb_onehot", {31'd0, $countones(a_av) > 1}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (a_av[i]) begin
          if (arb_q.size() == 0) begin
            chk("arb_unexpected", i, 32'hff);
          end else begin
            logic [4:0] e;
            e = arb_q.pop_front();
            chk("arb_src", {30'd0, a_src[i]}, {30'd0, e[4:3]});
            chk("arb_tag", {29'd0, a_tag[i]}, {29'd0, e[2:0]});
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(sb.size() == 0 && pending == 3'd0 && !req && !ack_valid) && n < 200) begin
      step();
      n++;
    end
    chk(name, {31'd0, n >= 200}, 32'd0);
  endtask

  task automatic push_hs(input logic [2:0] t);
    int n;
    done_valid = 1'b1;
    done_tag   = t;
    n = 0;
    while (!done_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_timeout", {31'd0, n >= 50}, 32'd0);
    sb.push_back({SRC, t});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; done_valid = 1'b0; done_tag = 3'd0; grant = 1'b0;
    a_dv = 4'b0000; arb_en = 1'b0;
    for (int i = 0; i < 4; i++) a_tin[i] = 3'd0;

    // reset state
    step(); step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_ack_valid", {31'd0, ack_valid}, 32'd0);
    chk("rst_ack_tag", {29'd0, ack_tag}, 32'd0);
    chk("rst_ack_src", {30'd0, ack_src}, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_err}, 32'd0);
    chk("rst_done_ready", {31'd0, done_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // single ack with grant held high, cycle-exact latency
    grant = 1'b1;
    done_valid = 1'b1; done_tag = 3'd5; sb.push_back({SRC, 3'd5});
    step();
    done_valid = 1'b0;
    chk("t1_pending1", {29'd0, pending}, 32'd1);
    chk("t1_idle_req", {31'd0, req}, 32'd0);
    step();
    chk("t1_req", {31'd0, req}, 32'd1);
    chk("t1_no_ack", {31'd0, ack_valid}, 32'd0);
    step();
    chk("t1_drive_req", {31'd0, req}, 32'd0);
    chk("t1_drive_valid", {31'd0, ack_valid}, 32'd1);
    chk("t1_drive_tag", {29'd0, ack_tag}, 32'd5);
    chk("t1_drive_src", {30'd0, ack_src}, {30'd0, SRC});
    step();
    chk("t1_done_valid", {31'd0, ack_valid}, 32'd0);
    chk("t1_done_req", {31'd0, req}, 32'd0);
    chk("t1_done_pending", {29'd0, pending}, 32'd0);
    chk("t1_done_tag", {29'd0, ack_tag}, 32'd0);

    // grant stall
    grant = 1'b0;
    done_valid = 1'b1; done_tag = 3'd3; sb.push_back({SRC, 3'd3});
    step();
    done_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t2_req_held", {30'd0, req, ack_valid}, 32'h2);
      step();
    end
    grant = 1'b1;
    step();
    chk("t2_drive_tag", {28'd0, ack_valid, ack_tag}, 32'hb);
    wait_drain("t2_drain");

    // fill then overflow
    grant = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      done_valid = 1'b1; done_tag = 3'(t); sb.push_back({SRC, 3'(t)});
      step();
    end
    done_tag = 3'd7;
    chk("t3_full_ready", {31'd0, done_ready}, 32'd0);
    chk("t3_full_pending", {29'd0, pending}, 32'd4);
    step();
    done_valid = 1'b0;
    chk("t3_overflow", {31'd0, overflow_err}, 32'd1);
    chk("t3_pending_kept", {29'd0, pending}, 32'd4);
    grant = 1'b1;
    wait_drain("t3_drain");
    chk("t3_overflow_sticky", {31'd0, overflow_err}, 32'd1);

    // wrap-around with pushes overlapping DRIVE cycles
    for (int k = 0; k < 10; k++) push_hs(3'(k % 8));
    done_valid = 1'b0;
    wait_drain("t4_drain");

    // reset while driving
    done_valid = 1'b1; done_tag = 3'd6; sb.push_back({SRC, 3'd6});
    step();
    done_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!ack_valid && n < 20) begin
        step();
        n++;
      end
      chk("t5_reach_drive", {31'd0, ack_valid}, 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, ack_valid}, 32'd0);
    chk("t5_async_req", {31'd0, req}, 32'd0);
    chk("t5_async_pending", {29'd0, pending}, 32'd0);
    chk("t5_async_overflow", {31'd0, overflow_err}, 32'd0);
    chk("t5_async_tag", {27'd0, ack_src, ack_tag}, 32'd0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_quiet", {29'd0, req, ack_valid, |pending}, 32'd0);
    end

    // first edge after reset release accepts a push
    rst_n = 1'b0;
    done_valid = 1'b1; done_tag = 3'd2;
    #2 rst_n = 1'b1;
    sb.push_back({SRC, 3'd2});
    step();
    done_valid = 1'b0;
    chk("t6_first_push", {29'd0, pending}, 32'd1);
    wait_drain("t6_drain");

    // four sources on one arbiter
    for (int i = 0; i < 4; i++) a_tin[i] = 3'(4 + i);
    a_dv = 4'b1111;
    step();
    a_dv = 4'b0000;
    arb_q.push_back({2'b11, 3'd7});
    arb_q.push_back({2'b00, 3'd4});
    arb_q.push_back({2'b10, 3'd6});
    arb_q.push_back({2'b01, 3'd5});
    arb_en = 1'b1;
    begin
      int n;
      n = 0;
      while (!(arb_q.size() == 0 && a_av == 4'b0000 && a_req == 4'b0000) && n < 60) begin
        step();
        n++;
      end
      chk("arb_drain", {31'd0, n >= 60}, 32'd0);
    end
    chk("arb_pending", {20'd0, a_pend[0], a_pend[1], a_pend[2], a_pend[3]}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
